fifo_rd_drain: RTL and testbench

- Read-side consumer of the team's FIFO, in the r_clk domain.
- Watches fifo_empty, issues rd_req and captures data_out one cycle later into a small ring skid buffer.
- Re-presents the words on a valid/ready stream, so downstream backpressure never drops or duplicates a FIFO word.
- Sustains one word per cycle when downstream is always ready.

---
 rtl/fifo_rd_drain.sv | 96 +++++++++
 tb/tb_fifo_rd_drain.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO drain: issues rd_req against a credit count, captures data_out into a
// ring skid buffer and re-presents it on a valid/ready stream. FIFO_RD_STATS_EN adds rd_count.

package fifo_rd_drain_pkg;
    parameter int DATA_WIDTH = 8;
endpackage

module fifo_rd_drain #(
    parameter int DATA_WIDTH = fifo_rd_drain_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           r_clk,
    input  logic                           rrst,
    input  logic                           drain_en,
    input  logic                           fifo_empty,
    input  logic [DATA_WIDTH-1:0]          data_out,
    output logic                           rd_req,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]           rd_count
`endif
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH+1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    if (BUF_DEPTH < 3 || BUF_DEPTH > 16 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_rd_drain: BUF_DEPTH must be 3..16 and CNT_WIDTH >= 1");
    end

    logic [DATA_WIDTH-1:0] buffer [BUF_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  rd_pend;
    logic                  active;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits count the in-flight word too, so a full buffer can never be overrun.
    assign credit  = {1'b0, buf_count} + (CW+1)'(rd_pend);
    assign rd_req  = active & drain_en & ~fifo_empty & (credit < (CW+1)'(BUF_DEPTH));
    assign push    = rd_pend;
    assign m_valid = (buf_count != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? buffer[rptr] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            active    <= 1'b0;
            rd_pend   <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            buf_count <= '0;
        end else begin
            active  <= 1'b1;
            rd_pend <= rd_req;
            if (push) wptr <= next_ptr(wptr);
            if (pop)  rptr <= next_ptr(rptr);
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    // NOTE: storage has no reset; m_data is gated by m_valid so stale entries never show.
    always_ff @(posedge r_clk) begin
        if (push) buffer[wptr] <= data_out;
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            rd_count <= '0;
        end else if (rd_req) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`else
    // Read statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: behavioural FIFO model, expected-word scoreboard
// and a negedge monitor that checks every accepted stream word.

module tb_fifo_rd_drain;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          r_clk = 1'b0;
    logic          rrst = 1'b0;
    logic          drain_en = 1'b0;
    logic          m_ready = 1'b0;
    logic          hold_empty = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] data_out = '0;
    logic          rd_req;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [2:0]    buf_count;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]   rd_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int            fifo_lvl = 0;
    logic          req_s = 1'b0;

    int cyc = 0;
    int req_cnt, val_cnt, pop_cnt, first_req, first_val, last_val, max_cnt, wraps;
    logic [1:0] prev_rptr = '0;

    assign fifo_empty = hold_empty | (fifo_lvl == 0);

    always #5 r_clk = ~r_clk;

    fifo_rd_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .r_clk      (r_clk),
        .rrst       (rrst),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .data_out   (data_out),
        .rd_req     (rd_req),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_count  (buf_count)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic load(input logic [DW-1:0] base, input logic [DW-1:0] step, input int n);
        logic [DW-1:0] w;
        w = base;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(w);
            exp_q.push_back(w);
            w = w + step;
        end
        fifo_lvl = fifo_q.size();
    endtask

    task automatic clr_stats();
        req_cnt = 0; val_cnt = 0; pop_cnt = 0;
        first_req = -1; first_val = -1; last_val = -1;
        max_cnt = 0; wraps = 0;
    endtask

    always @(posedge r_clk) cyc++;

    // Behavioural FIFO: a request seen in a cycle pops a word that is valid the next cycle.
    initial begin
        forever begin
            @(posedge r_clk);
            #1;
            if (req_s) begin
                check("rd_on_empty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) data_out = fifo_q.pop_front();
                fifo_lvl = fifo_q.size();
            end
        end
    end

    // Monitor: samples mid-cycle, gathers statistics and scores every accepted word.
    always @(negedge r_clk) begin
        req_s = rd_req;
        if (rd_req) begin
            req_cnt++;
            if (first_req < 0) first_req = cyc;
        end
        if (m_valid) begin
            val_cnt++;
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
        if (dut.rptr == 2'd0 && prev_rptr != 2'd0) wraps++;
        prev_rptr = dut.rptr;
        if (m_valid && m_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no word", m_data);
            end else begin
                check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        clr_stats();

        // Reset state.
        #1;
        check("rst_rd_req",    32'(rd_req),    32'd0);
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        check("rst_m_data",    32'(m_data),    32'd0);
        tick(2);
        @(negedge r_clk);
        rrst = 1'b1;
        tick(1);

        // Basic transfer.
        load(8'h11, 8'h11, 3);
        m_ready = 1'b1;
        drain_en = 1'b1;
        clr_stats();
        tick(8);
        check("basic_req_cnt",   32'(req_cnt), 32'd3);
        check("basic_latency",   32'(first_val - first_req), 32'd2);
        check("basic_val_cnt",   32'(val_cnt), 32'd3);
        check("basic_val_span",  32'(last_val - first_val), 32'd2);
`ifdef FIFO_RD_STATS_EN
        check("basic_rd_count",  32'(rd_count), 32'd3);
`endif

        // Backpressure.
        m_ready = 1'b0;
        load(8'hA0, 8'h01, 10);
        clr_stats();
        tick(10);
        check("bp_req_cnt",   32'(req_cnt),   32'd4);
        check("bp_buf_count", 32'(buf_count), 32'd4);
        check("bp_m_data",    32'(m_data),    32'hA0);
        tick(3);
        check("bp_m_data_hold", 32'(m_data),  32'hA0);
        check("bp_req_hold",    32'(req_cnt), 32'd4);
        clr_stats();
        m_ready = 1'b1;
        tick(20);
        check("bp_pop_cnt",  32'(pop_cnt), 32'd10);
        check("bp_no_gaps",  32'(last_val - first_val), 32'd9);

        // Empty boundary.
        hold_empty = 1'b1;
        load(8'hC1, 8'h01, 3);
        clr_stats();
        tick(6);
        check("empty_req_cnt", 32'(req_cnt), 32'd0);
        check("empty_val_cnt", 32'(val_cnt), 32'd0);
        clr_stats();
        hold_empty = 1'b0;
        tick(1);
        hold_empty = 1'b1;
        tick(6);
        check("pulse_req_cnt", 32'(req_cnt), 32'd1);
        check("pulse_pop_cnt", 32'(pop_cnt), 32'd1);
        hold_empty = 1'b0;
        tick(8);

        // Simultaneous push/pop with toggling m_ready.
        m_ready = 1'b0;
        load(8'h01, 8'h01, 8);
        clr_stats();
        repeat (30) begin
            m_ready = ~m_ready;
            tick(1);
        end
        check("pp_max_le_depth", 32'(max_cnt <= DEPTH), 32'd1);
        check("pp_pop_cnt",      32'(pop_cnt), 32'd8);
        check("pp_wraps_ge_2",   32'(wraps >= 2), 32'd1);

        // Reset mid-operation with three words buffered and one in flight.
        m_ready = 1'b0;
        tick(1);
        load(8'h40, 8'h01, 10);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge r_clk);
            if (buf_count == 3'd3 && dut.rd_pend) ok = 1'b1;
        end
        check("mid_rst_setup", 32'(ok), 32'd1);
        rrst = 1'b0;
        req_s = 1'b0;
        #1;
        check("mid_rst_rd_req",    32'(rd_req),    32'd0);
        check("mid_rst_m_valid",   32'(m_valid),   32'd0);
        check("mid_rst_buf_count", 32'(buf_count), 32'd0);
        check("mid_rst_m_data",    32'(m_data),    32'd0);
        check("mid_rst_fifo_lvl",  32'(fifo_lvl),  32'd6);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h44 + 8'(i));
        @(negedge r_clk);
        rrst = 1'b1;
        tick(2);
        clr_stats();
        m_ready = 1'b1;
        tick(20);
        check("mid_rst_pop_cnt", 32'(pop_cnt), 32'd6);

        // drain_en gating.
        m_ready = 1'b0;
        drain_en = 1'b0;
        tick(1);
        load(8'h60, 8'h01, 7);
        drain_en = 1'b1;
        tick(2);
        drain_en = 1'b0;
        clr_stats();
        tick(6);
        check("den_req_cnt",   32'(req_cnt),   32'd0);
        check("den_buf_count", 32'(buf_count), 32'd2);
        check("den_fifo_lvl",  32'(fifo_lvl),  32'd5);
        m_ready = 1'b1;
        clr_stats();
        tick(6);
        check("den_drain_pops", 32'(pop_cnt), 32'd2);
        check("den_drain_req",  32'(req_cnt), 32'd0);
        drain_en = 1'b1;
        clr_stats();
        tick(15);
        check("den_resume_pops", 32'(pop_cnt), 32'd5);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
